// File: rtl/des_cbc_ctrl.sv
// des_cbc_ctrl: CBC chaining controller wrapped around an external DES core.
//
// Accepts one 64-bit block at a time, applies the CBC pre/post XOR around a
// single DES core operation, and presents the result on a valid/ready output.
// IV, key and mode are latched by a load pulse while idle; the chain value
// persists across blocks until the next load.
//
// Ports:
//   i_Clk, i_Rst            clock, synchronous active-high reset
//   i_fIvLoad, i_IV, i_Key,
//   i_fDec                  IV/key/mode load (honoured only when idle)
//   i_fValid, i_Text,
//   o_fReady                input block stream
//   o_fValid, o_Text,
//   i_fReady                output block stream
//   o_fStart, o_fCoreDec,
//   o_CoreKey, o_CoreText   request to the DES core
//   i_fCoreDone, i_CoreText core completion (data valid in the done cycle only)
//   o_fBusy, o_fErr         not-idle flag, sticky core-timeout error
module des_cbc_ctrl #(
    parameter int unsigned CORE_TIMEOUT = 32
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_fIvLoad,
    input  logic [63:0] i_IV,
    input  logic [63:0] i_Key,
    input  logic        i_fDec,
    input  logic        i_fValid,
    input  logic [63:0] i_Text,
    output logic        o_fReady,
    output logic        o_fValid,
    output logic [63:0] o_Text,
    input  logic        i_fReady,
    output logic        o_fStart,
    output logic        o_fCoreDec,
    output logic [63:0] o_CoreKey,
    output logic [63:0] o_CoreText,
    input  logic        i_fCoreDone,
    input  logic [63:0] i_CoreText,
    output logic        o_fBusy,
    output logic        o_fErr
);

    localparam int unsigned       TimerW   = $clog2(CORE_TIMEOUT + 1);
    localparam logic [TimerW-1:0] TimerMax = TimerW'(CORE_TIMEOUT);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StOut   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [63:0]       chain_q, chain_d;
    logic [63:0]       key_q, key_d;
    logic              mode_q, mode_d;
    logic [63:0]       in_q, in_d;
    logic [63:0]       out_q, out_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              err_q, err_d;
    logic              accept;

    assign o_fReady = (state_q == StIdle);
    assign accept   = i_fValid & o_fReady;

    always_comb begin
        state_d = state_q;
        chain_d = chain_q;
        key_d   = key_q;
        mode_d  = mode_q;
        in_d    = in_q;
        out_d   = out_q;
        timer_d = timer_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                // Load and accept may coincide; the new IV/key/mode are registered
                // before ISSUE, so they apply to the block accepted here.
                if (i_fIvLoad) begin
                    chain_d = i_IV;
                    key_d   = i_Key;
                    mode_d  = i_fDec;
                    err_d   = 1'b0;
                end
                if (accept) begin
                    in_d    = i_Text;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                // A done in the last allowed cycle still wins over the timeout.
                if (i_fCoreDone) begin
                    if (mode_q) begin
                        out_d   = i_CoreText ^ chain_q;
                        chain_d = in_q;
                    end else begin
                        out_d   = i_CoreText;
                        chain_d = i_CoreText;
                    end
                    state_d = StOut;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (timer_d == TimerMax) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StOut: begin
                if (i_fReady) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= StIdle;
            chain_q <= '0;
            key_q   <= '0;
            mode_q  <= 1'b0;
            in_q    <= '0;
            out_q   <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            chain_q <= chain_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            in_q    <= in_d;
            out_q   <= out_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    assign o_fStart   = (state_q == StIssue);
    assign o_fCoreDec = mode_q;
    assign o_CoreKey  = key_q;
    // Encrypt pre-XORs the chain; decrypt post-XORs it on the way out.
    assign o_CoreText = mode_q ? in_q : (in_q ^ chain_q);
    assign o_fValid   = (state_q == StOut);
    assign o_Text     = out_q;
    assign o_fBusy    = (state_q != StIdle);
    assign o_fErr     = err_q;

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// tb_des_cbc_ctrl: self-checking bench for des_cbc_ctrl.
// Known-answer vectors from a table, hand-written timeout/reset sequences, and
// randomized blocks checked against a CBC reference model; the DES core is
// emulated by the bench returning a chosen response after a chosen latency.
module tb_des_cbc_ctrl;

    logic        clk;
    logic        i_Rst;
    logic        i_fIvLoad;
    logic [63:0] i_IV;
    logic [63:0] i_Key;
    logic        i_fDec;
    logic        i_fValid;
    logic [63:0] i_Text;
    logic        o_fReady;
    logic        o_fValid;
    logic [63:0] o_Text;
    logic        i_fReady;
    logic        o_fStart;
    logic        o_fCoreDec;
    logic [63:0] o_CoreKey;
    logic [63:0] o_CoreText;
    logic        i_fCoreDone;
    logic [63:0] i_CoreText;
    logic        o_fBusy;
    logic        o_fErr;

    des_cbc_ctrl #(.CORE_TIMEOUT(32)) dut (
        .i_Clk       (clk),
        .i_Rst       (i_Rst),
        .i_fIvLoad   (i_fIvLoad),
        .i_IV        (i_IV),
        .i_Key       (i_Key),
        .i_fDec      (i_fDec),
        .i_fValid    (i_fValid),
        .i_Text      (i_Text),
        .o_fReady    (o_fReady),
        .o_fValid    (o_fValid),
        .o_Text      (o_Text),
        .i_fReady    (i_fReady),
        .o_fStart    (o_fStart),
        .o_fCoreDec  (o_fCoreDec),
        .o_CoreKey   (o_CoreKey),
        .o_CoreText  (o_CoreText),
        .i_fCoreDone (i_fCoreDone),
        .i_CoreText  (i_CoreText),
        .o_fBusy     (o_fBusy),
        .o_fErr      (o_fErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model state: chain, latched key/mode, sticky error.
    logic [63:0] m_chain = '0;
    logic [63:0] m_key   = '0;
    logic        m_mode  = 1'b0;
    logic        m_err   = 1'b0;

    typedef struct {
        logic        load;
        logic [63:0] iv;
        logic [63:0] key;
        logic        dec;
        logic [63:0] text;
        logic [63:0] resp;
        logic [63:0] exp_ct;
        logic [63:0] exp_out;
        int          lat;
        int          rdy;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // CBC rules at block level: returns expected core input and output block.
    task automatic model_block(input logic load, input logic [63:0] iv, input logic [63:0] key,
                               input logic dec, input logic [63:0] text,
                               input logic [63:0] resp, output logic [63:0] exp_ct,
                               output logic [63:0] exp_out);
        if (load) begin
            m_chain = iv;
            m_key   = key;
            m_mode  = dec;
            m_err   = 1'b0;
        end
        if (m_mode) begin
            exp_ct  = text;
            exp_out = resp ^ m_chain;
            m_chain = text;
        end else begin
            exp_ct  = text ^ m_chain;
            exp_out = resp;
            m_chain = resp;
        end
    endtask

    // Drives one block through the DUT; model state must already be updated.
    task automatic run_block(input logic load, input logic [63:0] iv, input logic [63:0] key,
                             input logic dec, input logic [63:0] text,
                             input logic [63:0] resp, input int lat, input int rdy,
                             input logic [63:0] exp_ct, input logic [63:0] exp_out,
                             input bit noisy, input string tag);
        int          extra_starts;
        int          early_valid;
        logic [63:0] held;
        extra_starts = 0;
        early_valid  = 0;
        chk({tag, " ready_idle"}, 64'(o_fReady), 64'd1);
        i_fIvLoad = load;
        i_IV      = iv;
        i_Key     = key;
        i_fDec    = dec;
        i_fValid  = 1'b1;
        i_Text    = text;
        tick();
        i_fIvLoad = 1'b0;
        i_fValid  = 1'b0;
        i_Text    = $urandom;
        // ISSUE
        chk({tag, " start"}, 64'(o_fStart), 64'd1);
        chk({tag, " core_text"}, o_CoreText, exp_ct);
        chk({tag, " core_key"}, o_CoreKey, m_key);
        chk({tag, " core_dec"}, 64'(o_fCoreDec), 64'(m_mode));
        chk({tag, " ready_issue"}, 64'(o_fReady), 64'd0);
        tick();
        // WAIT: lat-1 idle cycles, then done
        for (int i = 0; i < lat - 1; i++) begin
            if (o_fStart) extra_starts++;
            if (o_fValid) early_valid++;
            if (noisy) begin
                i_fIvLoad = 1'b1;
                i_IV      = {$urandom, $urandom};
                i_Key     = {$urandom, $urandom};
                i_fDec    = 1'($urandom);
            end
            tick();
            i_fIvLoad = 1'b0;
        end
        if (o_fStart) extra_starts++;
        if (o_fValid) early_valid++;
        i_fCoreDone = 1'b1;
        i_CoreText  = resp;
        tick();
        i_fCoreDone = 1'b0;
        i_CoreText  = {$urandom, $urandom};
        // OUT
        chk({tag, " valid"}, 64'(o_fValid), 64'd1);
        chk({tag, " out_text"}, o_Text, exp_out);
        held = o_Text;
        for (int i = 0; i < rdy; i++) begin
            if (o_fStart) extra_starts++;
            chk({tag, " ready_out"}, 64'(o_fReady), 64'd0);
            if (noisy) begin
                i_fCoreDone = 1'b1;
                i_CoreText  = {$urandom, $urandom};
            end
            tick();
            i_fCoreDone = 1'b0;
            chk({tag, " out_hold"}, o_Text, held);
            chk({tag, " valid_hold"}, 64'(o_fValid), 64'd1);
        end
        chk({tag, " one_start"}, 64'(extra_starts), 64'd0);
        chk({tag, " no_early_valid"}, 64'(early_valid), 64'd0);
        i_fReady = 1'b1;
        tick();
        i_fReady = 1'b0;
        chk({tag, " valid_drop"}, 64'(o_fValid), 64'd0);
        chk({tag, " busy_drop"}, 64'(o_fBusy), 64'd0);
        chk({tag, " err"}, 64'(o_fErr), 64'(m_err));
    endtask

    task automatic load_only(input logic [63:0] iv, input logic [63:0] key, input logic dec);
        i_fIvLoad = 1'b1;
        i_IV      = iv;
        i_Key     = key;
        i_fDec    = dec;
        tick();
        i_fIvLoad = 1'b0;
        m_chain   = iv;
        m_key     = key;
        m_mode    = dec;
        m_err     = 1'b0;
        chk("load key", o_CoreKey, key);
        chk("load dec", 64'(o_fCoreDec), 64'(dec));
        chk("load err_clear", 64'(o_fErr), 64'd0);
    endtask

    initial begin
        logic [63:0] e_ct, e_out, txt, rsp, iv, key;
        logic        ld, dc;
        int          n;

        vecs[0] = '{1'b1, 64'h0, 64'h133457799BBCDFF1, 1'b0, 64'h0123456789ABCDEF,
                    64'h85E813540F0AB405, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 3, 0};
        vecs[1] = '{1'b0, 64'h0, 64'h0, 1'b0, 64'h0123456789ABCDEF,
                    64'hD0A1C7E39B4F2256, 64'h84CB563386A179EA, 64'hD0A1C7E39B4F2256, 2, 5};
        vecs[2] = '{1'b1, 64'h0, 64'h133457799BBCDFF1, 1'b1, 64'h85E813540F0AB405,
                    64'h0123456789ABCDEF, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 4, 1};
        vecs[3] = '{1'b0, 64'h0, 64'h0, 1'b0, 64'hD0A1C7E39B4F2256,
                    64'h84CB563386A179EA, 64'hD0A1C7E39B4F2256, 64'h0123456789ABCDEF, 1, 0};

        i_Rst = 1'b1; i_fIvLoad = 1'b0; i_IV = '0; i_Key = '0; i_fDec = 1'b0;
        i_fValid = 1'b0; i_Text = '0; i_fReady = 1'b0; i_fCoreDone = 1'b0; i_CoreText = '0;
        tick();
        tick();
        i_Rst = 1'b0;
        chk("rst ready", 64'(o_fReady), 64'd1);
        chk("rst valid", 64'(o_fValid), 64'd0);
        chk("rst text", o_Text, 64'd0);
        chk("rst start", 64'(o_fStart), 64'd0);
        chk("rst busy", 64'(o_fBusy), 64'd0);
        chk("rst err", 64'(o_fErr), 64'd0);
        chk("rst key", o_CoreKey, 64'd0);
        chk("rst core_text", o_CoreText, 64'd0);
        chk("rst core_dec", 64'(o_fCoreDec), 64'd0);

        // Known-answer CBC encrypt then decrypt of the same message.
        for (int i = 0; i < 4; i++) begin
            model_block(vecs[i].load, vecs[i].iv, vecs[i].key, vecs[i].dec, vecs[i].text,
                        vecs[i].resp, e_ct, e_out);
            run_block(vecs[i].load, vecs[i].iv, vecs[i].key, vecs[i].dec, vecs[i].text,
                      vecs[i].resp, vecs[i].lat, vecs[i].rdy, vecs[i].exp_ct,
                      vecs[i].exp_out, 1'b0, $sformatf("kat%0d", i));
        end

        // Done in the last allowed WAIT cycle must still complete normally.
        txt = {$urandom, $urandom};
        rsp = {$urandom, $urandom};
        model_block(1'b0, '0, '0, 1'b0, txt, rsp, e_ct, e_out);
        run_block(1'b0, '0, '0, 1'b0, txt, rsp, 32, 0, e_ct, e_out, 1'b0, "lastcycle");

        // Timeout: core never answers.
        load_only(64'hA5A5_0F0F_1234_5678, 64'h1111_2222_3333_4444, 1'b0);
        i_fValid = 1'b1;
        i_Text   = 64'hDEAD_BEEF_0000_FFFF;
        tick();
        i_fValid = 1'b0;
        tick();
        n = 0;
        while (o_fBusy && n < 100) begin
            if (o_fValid) chk("timeout spurious_valid", 64'(o_fValid), 64'd0);
            n++;
            tick();
        end
        chk("timeout wait_cycles", 64'(n), 64'd32);
        chk("timeout err", 64'(o_fErr), 64'd1);
        chk("timeout ready", 64'(o_fReady), 64'd1);
        m_err = 1'b1;
        // Chain must be untouched by the aborted block; error stays sticky.
        txt = {$urandom, $urandom};
        rsp = {$urandom, $urandom};
        model_block(1'b0, '0, '0, 1'b0, txt, rsp, e_ct, e_out);
        run_block(1'b0, '0, '0, 1'b0, txt, rsp, 2, 0, e_ct, e_out, 1'b0, "after_timeout");
        load_only({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);

        // Reset mid-WAIT, then a stale done.
        i_fValid = 1'b1;
        i_Text   = {$urandom, $urandom};
        tick();
        i_fValid = 1'b0;
        tick();
        tick();
        i_Rst = 1'b1;
        tick();
        i_Rst = 1'b0;
        chk("midrst ready", 64'(o_fReady), 64'd1);
        chk("midrst busy", 64'(o_fBusy), 64'd0);
        i_fCoreDone = 1'b1;
        i_CoreText  = {$urandom, $urandom};
        tick();
        i_fCoreDone = 1'b0;
        chk("midrst valid", 64'(o_fValid), 64'd0);
        chk("midrst ready2", 64'(o_fReady), 64'd1);
        chk("midrst key", o_CoreKey, 64'd0);
        chk("midrst core_text", o_CoreText, 64'd0);
        tick();
        chk("midrst valid2", 64'(o_fValid), 64'd0);
        m_chain = '0; m_key = '0; m_mode = 1'b0; m_err = 1'b0;
        txt = {$urandom, $urandom};
        rsp = {$urandom, $urandom};
        model_block(1'b0, '0, '0, 1'b0, txt, rsp, e_ct, e_out);
        run_block(1'b0, '0, '0, 1'b0, txt, rsp, 3, 0, e_ct, e_out, 1'b0, "after_rst");

        // Randomized message stream with noise on ignored inputs.
        for (int b = 0; b < 40; b++) begin
            ld  = ($urandom_range(0, 3) == 0);
            iv  = {$urandom, $urandom};
            key = {$urandom, $urandom};
            dc  = 1'($urandom);
            txt = {$urandom, $urandom};
            rsp = {$urandom, $urandom};
            model_block(ld, iv, key, dc, txt, rsp, e_ct, e_out);
            run_block(ld, iv, key, dc, txt, rsp, $urandom_range(1, 8), $urandom_range(0, 3),
                      e_ct, e_out, 1'b1, $sformatf("rnd%0d", b));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
